// File: rtl/pipe_hazard_pkg.sv
// Shared types and helpers for the pipeline hazard/forwarding controller.
// Optional multiply/divide scoreboard is enabled with PIPE_HAZARD_MULTDIV_EN.
package pipe_hazard_pkg;

    // Entry fields are sized for the widest supported configuration; narrower
    // addresses and ready stages are zero-extended on entry.
    localparam int unsigned ENTRY_RD_W  = 8;
    localparam int unsigned ENTRY_RDY_W = 8;

    localparam int unsigned SEL_REGFILE = 0;

    typedef struct packed {
        logic                   valid;
        logic                   wr_en;
        logic [ENTRY_RD_W-1:0]  rd;
        logic [ENTRY_RDY_W-1:0] rdy;
    } entry_t;

    function automatic int unsigned sel_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int unsigned clamp_rdy(input int unsigned rdy, input int unsigned depth);
        if (rdy == 0) begin
            return 1;
        end
        if (rdy > depth) begin
            return depth;
        end
        return rdy;
    endfunction

endpackage

// File: rtl/hazard_src_match.sv
// Youngest-writer search for one decode source: yields a forward stage or a hazard.
module hazard_src_match
    import pipe_hazard_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned DEPTH      = 3,
    parameter int unsigned SEL_W      = sel_width(DEPTH)
) (
    input  entry_t                entries [DEPTH],
    input  logic [REG_ADDR_W-1:0] src,
    input  logic                  used,
    output logic [SEL_W-1:0]      hit_sel,
    output logic                  hazard
);

    logic [ENTRY_RD_W-1:0] src_ext;
    logic                  found;

    assign src_ext = ENTRY_RD_W'(src);

    always_comb begin
        hit_sel = SEL_W'(SEL_REGFILE);
        hazard  = 1'b0;
        found   = 1'b0;
        if (used && (src != '0)) begin
            // Ascending scan: the first hit is the youngest writer and masks older ones.
            for (int unsigned k = 0; k < DEPTH; k++) begin
                if (!found && entries[k].valid && entries[k].wr_en &&
                    (entries[k].rd == src_ext)) begin
                    found = 1'b1;
                    if ((k + 1) >= clamp_rdy(32'(entries[k].rdy), DEPTH)) begin
                        hit_sel = SEL_W'(k + 1);
                    end else begin
                        hazard = 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard detection and forwarding control across DEPTH post-decode stages.
// Define PIPE_HAZARD_MULTDIV_EN to add the multi-cycle md busy tracker.
module pipe_hazard_ctrl
    import pipe_hazard_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned DEPTH      = 3,
    parameter int unsigned NUM_SRC    = 2,
    parameter int unsigned SEL_W      = sel_width(DEPTH)
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          dec_valid,
    input  logic [NUM_SRC*REG_ADDR_W-1:0] dec_src,
    input  logic [NUM_SRC-1:0]            dec_src_used,
    input  logic                          dec_wr_en,
    input  logic [REG_ADDR_W-1:0]         dec_rd,
    input  logic [SEL_W-1:0]              dec_rdy,
    input  logic                          flush,
`ifdef PIPE_HAZARD_MULTDIV_EN
    input  logic                          dec_is_md,
    input  logic                          md_done,
    output logic                          md_busy,
`endif
    output logic                          stall,
    output logic                          issue,
    output logic [NUM_SRC*SEL_W-1:0]      fwd_sel
);

    entry_t             pipe_q [DEPTH];
    entry_t             pipe_d [DEPTH];
    logic [SEL_W-1:0]   hit_sel [NUM_SRC];
    logic [NUM_SRC-1:0] src_hazard;
    logic               md_hazard;
    logic               entry_wr_en;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        hazard_src_match #(
            .REG_ADDR_W (REG_ADDR_W),
            .DEPTH      (DEPTH),
            .SEL_W      (SEL_W)
        ) u_match (
            .entries (pipe_q),
            .src     (dec_src[i*REG_ADDR_W +: REG_ADDR_W]),
            .used    (dec_src_used[i]),
            .hit_sel (hit_sel[i]),
            .hazard  (src_hazard[i])
        );
    end

`ifdef PIPE_HAZARD_MULTDIV_EN
    logic                  md_busy_q;
    logic [REG_ADDR_W-1:0] md_rd_q;

    always_comb begin
        md_hazard = 1'b0;
        if (md_busy_q) begin
            if (dec_is_md || (dec_wr_en && (dec_rd == md_rd_q))) begin
                md_hazard = 1'b1;
            end
            for (int unsigned i = 0; i < NUM_SRC; i++) begin
                if (dec_src_used[i] && (dec_src[i*REG_ADDR_W +: REG_ADDR_W] != '0) &&
                    (dec_src[i*REG_ADDR_W +: REG_ADDR_W] == md_rd_q)) begin
                    md_hazard = 1'b1;
                end
            end
        end
    end

    // The md unit owns its result; it never appears as a writer in the shift pipe.
    assign entry_wr_en = dec_wr_en & ~dec_is_md;
    assign md_busy     = md_busy_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            md_busy_q <= 1'b0;
            md_rd_q   <= '0;
        end else if (issue && dec_is_md) begin
            md_busy_q <= 1'b1;
            md_rd_q   <= dec_rd;
        end else if (md_done) begin
            md_busy_q <= 1'b0;
        end
    end
`else
    assign md_hazard   = 1'b0;
    assign entry_wr_en = dec_wr_en;
`endif

    assign stall = ~reset & dec_valid & ((|src_hazard) | md_hazard) & ~flush;
    assign issue = ~reset & dec_valid & ~stall & ~flush;

    always_comb begin
        fwd_sel = '0;
        if (!reset) begin
            for (int unsigned i = 0; i < NUM_SRC; i++) begin
                fwd_sel[i*SEL_W +: SEL_W] = hit_sel[i];
            end
        end
    end

    // Older instructions always drain; only the stage-1 slot sees bubbles.
    always_comb begin
        pipe_d[0] = '0;
        if (issue) begin
            pipe_d[0].valid = 1'b1;
            pipe_d[0].wr_en = entry_wr_en;
            pipe_d[0].rd    = ENTRY_RD_W'(dec_rd);
            pipe_d[0].rdy   = ENTRY_RDY_W'(dec_rdy);
        end
        for (int unsigned k = 1; k < DEPTH; k++) begin
            pipe_d[k] = pipe_q[k-1];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                pipe_q[k] <= '0;
            end
        end else begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                pipe_q[k] <= pipe_d[k];
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with a queue-based scoreboard.
module tb_pipe_hazard_ctrl;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned DEPTH      = 3;
    localparam int unsigned NUM_SRC    = 2;
    localparam int unsigned SEL_W      = 2;

    logic                          clock = 1'b0;
    logic                          reset;
    logic                          dec_valid;
    logic [NUM_SRC*REG_ADDR_W-1:0] dec_src;
    logic [NUM_SRC-1:0]            dec_src_used;
    logic                          dec_wr_en;
    logic [REG_ADDR_W-1:0]         dec_rd;
    logic [SEL_W-1:0]              dec_rdy;
    logic                          flush;
    logic                          stall;
    logic                          issue;
    logic [NUM_SRC*SEL_W-1:0]      fwd_sel;
`ifdef PIPE_HAZARD_MULTDIV_EN
    logic                          dec_is_md = 1'b0;
    logic                          md_done   = 1'b0;
    logic                          md_busy;
`endif

    typedef struct {
        logic       stall;
        logic       issue;
        logic [3:0] fwd;
        string      tag;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    always #5 clock = ~clock;

    pipe_hazard_ctrl #(
        .REG_ADDR_W (REG_ADDR_W),
        .DEPTH      (DEPTH),
        .NUM_SRC    (NUM_SRC)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .dec_valid    (dec_valid),
        .dec_src      (dec_src),
        .dec_src_used (dec_src_used),
        .dec_wr_en    (dec_wr_en),
        .dec_rd       (dec_rd),
        .dec_rdy      (dec_rdy),
        .flush        (flush),
`ifdef PIPE_HAZARD_MULTDIV_EN
        .dec_is_md    (dec_is_md),
        .md_done      (md_done),
        .md_busy      (md_busy),
`endif
        .stall        (stall),
        .issue        (issue),
        .fwd_sel      (fwd_sel)
    );

    // One decode cycle: drive after the edge, compare on the falling edge.
    task automatic step(input string tag, input logic rst, input logic v,
                        input logic [4:0] s0, input logic [4:0] s1, input logic [1:0] used,
                        input logic wr, input logic [4:0] rd, input logic [1:0] rdy,
                        input logic fl, input logic e_stall, input logic e_issue,
                        input logic [1:0] e_f0, input logic [1:0] e_f1);
        exp_t e;
        @(posedge clock);
        #1;
        reset        = rst;
        dec_valid    = v;
        dec_src      = {s1, s0};
        dec_src_used = used;
        dec_wr_en    = wr;
        dec_rd       = rd;
        dec_rdy      = rdy;
        flush        = fl;
        e.stall = e_stall;
        e.issue = e_issue;
        e.fwd   = {e_f1, e_f0};
        e.tag   = tag;
        sb.push_back(e);
        @(negedge clock);
        e = sb.pop_front();
        checks++;
        assert (stall === e.stall) else begin
            errors++;
            $error("FAIL %s stall: got %b want %b", e.tag, stall, e.stall);
        end
        checks++;
        assert (issue === e.issue) else begin
            errors++;
            $error("FAIL %s issue: got %b want %b", e.tag, issue, e.issue);
        end
        checks++;
        assert (fwd_sel === e.fwd) else begin
            errors++;
            $error("FAIL %s fwd_sel: got %h want %h", e.tag, fwd_sel, e.fwd);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        reset        = 1'b1;
        dec_valid    = 1'b0;
        dec_src      = '0;
        dec_src_used = '0;
        dec_wr_en    = 1'b0;
        dec_rd       = '0;
        dec_rdy      = '0;
        flush        = 1'b0;

        //   tag      rst v   s0  s1  used  wr rd  rdy fl  stall issue f0 f1
        step("rst1",  1, 1,  1,  0, 2'b01, 1,  1, 1, 0,   0, 0, 0, 0);
        step("rst2",  1, 1,  1,  0, 2'b01, 1,  1, 1, 0,   0, 0, 0, 0);
        // ALU back-to-back forwards from stage 1
        step("alu_a", 0, 1,  2,  0, 2'b11, 1,  1, 1, 0,   0, 1, 0, 0);
        step("alu_b", 0, 1,  1,  2, 2'b11, 1,  3, 1, 0,   0, 1, 1, 0);
        // Load-use: one stall cycle, then stage 2 and stage DEPTH forwarding
        step("lw4",   0, 1,  7,  0, 2'b01, 1,  4, 2, 0,   0, 1, 0, 0);
        step("use_s", 0, 1,  4,  3, 2'b11, 1,  5, 1, 0,   1, 0, 0, 2);
        step("use_f", 0, 1,  4,  3, 2'b11, 1,  5, 1, 0,   0, 1, 2, 3);
        // Writer to $0 never hazards; unused source gives regfile
        step("wr_r0", 0, 1,  1,  1, 2'b11, 1,  0, 1, 0,   0, 1, 0, 0);
        step("rd_r0", 0, 1,  0,  5, 2'b11, 0,  0, 1, 0,   0, 1, 0, 2);
        step("unuse", 0, 1,  5,  5, 2'b10, 0,  0, 1, 0,   0, 1, 0, 3);
        // Two writers to $6: youngest wins
        step("w6_a",  0, 1,  0,  0, 2'b00, 1,  6, 1, 0,   0, 1, 0, 0);
        step("w6_b",  0, 1,  0,  0, 2'b00, 1,  6, 1, 0,   0, 1, 0, 0);
        step("yng1",  0, 1,  6,  6, 2'b11, 0,  0, 1, 0,   0, 1, 1, 1);
        step("yng2",  0, 1,  6,  0, 2'b01, 1,  7, 2, 0,   0, 1, 2, 0);
        // Flush beats a pending load-use stall and inserts a bubble
        step("flush", 0, 1,  7,  0, 2'b01, 1,  8, 1, 1,   0, 0, 0, 0);
        step("bubbl", 0, 1,  8,  7, 2'b11, 0,  0, 1, 0,   0, 1, 0, 2);
        // rdy=3 producer: invalid decode never stalls, then one stall, then stage 3
        step("lw9",   0, 1,  0,  0, 2'b00, 1,  9, 3, 0,   0, 1, 0, 0);
        step("novld", 0, 0,  9,  0, 2'b01, 0,  0, 1, 0,   0, 0, 0, 0);
        step("r3_s",  0, 1,  9,  0, 2'b01, 0,  0, 1, 0,   1, 0, 0, 0);
        step("r3_f",  0, 1,  9,  0, 2'b01, 0,  0, 1, 0,   0, 1, 3, 0);
        // Stored rdy of 0 behaves as 1
        step("rdy0",  0, 1,  0,  0, 2'b00, 1, 10, 0, 0,   0, 1, 0, 0);
        step("rdy0u", 0, 1, 10,  0, 2'b01, 0,  0, 1, 0,   0, 1, 1, 0);
        // Reset during a stall drops it and clears all tracking
        step("lw11",  0, 1,  0,  0, 2'b00, 1, 11, 2, 0,   0, 1, 0, 0);
        step("stl11", 0, 1, 11, 10, 2'b11, 1, 12, 1, 0,   1, 0, 0, 3);
        step("rstst", 1, 1, 11, 10, 2'b11, 1, 12, 1, 0,   0, 0, 0, 0);
        step("postr", 0, 1, 11, 10, 2'b11, 1, 12, 1, 0,   0, 1, 0, 0);
        step("post2", 0, 1, 12,  0, 2'b01, 0,  0, 1, 0,   0, 1, 1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
